// File: rtl/cdce_spi_responder_if.sv
// 4-wire SPI bundle for the clock-chip config link.
// master drives clk/le/mosi; slave returns miso.
interface cdce_spi_responder_if;
  logic spi_clk;
  logic spi_le;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_clk, spi_le, spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_clk, spi_le, spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/cdce_spi_responder.sv
// SPI clock-chip stand-in: oversampled LSB-first 32-bit frames,
// shadow regs, readback on miso, write/eeprom/error strobes, frame count.
module cdce_spi_responder #(
  parameter int          NUM_REGS    = 9,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] REG_RST_VAL = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cdce_spi_responder_if.slave      spi,
  output logic [32*NUM_REGS-1:0]   reg_file_flat,
  output logic                     wr_stb,
  output logic [3:0]               wr_addr,
  output logic                     eeprom_stb,
  output logic                     frame_err,
  output logic [15:0]              frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT_IN, S_DECODE, S_SHIFT_OUT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sr, le_sr, mosi_sr;
  logic sclk_s, le_s, mosi_s;
  logic sclk_d, le_d;
  logic sclk_rise, sclk_fall, le_fall, le_rise;

  logic [31:0] shreg, oshr, rd_word;
  logic [5:0]  bit_cnt;
  logic [3:0]  rd_addr, wr_addr_q, nib;
  logic        rd_armed, frame_ok;
  logic        nib_wr, nib_rd, nib_ee;
  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sr <= '0;
      le_sr   <= '1;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      le_d    <= 1'b1;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi.spi_clk};
      le_sr   <= {le_sr[SYNC_STAGES-2:0], spi.spi_le};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi.spi_mosi};
      sclk_d  <= sclk_s;
      le_d    <= le_s;
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign le_s      = le_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign le_fall   = ~le_s & le_d;
  assign le_rise   = le_s & ~le_d;

  assign nib      = shreg[3:0];
  assign frame_ok = (bit_cnt == 6'd32);
  assign nib_wr   = ({28'd0, nib} < 32'(NUM_REGS));
  assign nib_rd   = (nib == 4'hE);
  assign nib_ee   = (nib == 4'hF);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == 4'(i)) rd_word = regs[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (le_fall)
          state_d = rd_armed ? S_SHIFT_OUT : S_SHIFT_IN;
      S_SHIFT_IN:
        if (le_rise) state_d = S_DECODE;
      S_DECODE:
        state_d = S_IDLE;
      S_SHIFT_OUT:
        if (le_rise) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_stb     = 1'b0;
    eeprom_stb = 1'b0;
    frame_err  = 1'b0;
    spi.spi_miso = 1'b0;
    unique case (state_q)
      S_SHIFT_IN:
        frame_err = le_fall;
      S_DECODE:
        if (!frame_ok) begin
          frame_err = 1'b1;
        end else begin
          unique case (1'b1)
            nib_wr:  wr_stb     = 1'b1;
            nib_rd:  ;
            nib_ee:  eeprom_stb = 1'b1;
            default: frame_err  = 1'b1;
          endcase
        end
      S_SHIFT_OUT:
        spi.spi_miso = oshr[0];
      default: ;
    endcase
  end

  assign wr_addr = wr_stb ? nib : wr_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      oshr      <= '0;
      bit_cnt   <= '0;
      rd_addr   <= '0;
      rd_armed  <= 1'b0;
      wr_addr_q <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= {REG_RST_VAL[31:4], 4'(i)};
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (le_fall && !rd_armed) bit_cnt <= '0;
          if (le_fall && rd_armed)  oshr    <= rd_word;
        end
        S_SHIFT_IN: begin
          // a second LE fall restarts the frame from bit 0
          if (le_fall) begin
            bit_cnt <= '0;
          end else if (sclk_rise && !le_s) begin
            shreg <= {mosi_s, shreg[31:1]};
            if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
          end
        end
        S_DECODE: begin
          if (frame_ok) frame_cnt <= frame_cnt + 16'd1;
          if (wr_stb) begin
            wr_addr_q <= nib;
            for (int i = 0; i < NUM_REGS; i++)
              if (nib == 4'(i)) regs[i] <= shreg;
          end
          if (frame_ok && nib_rd) begin
            rd_addr  <= shreg[7:4];
            rd_armed <= 1'b1;
          end
        end
        S_SHIFT_OUT: begin
          if (sclk_fall) oshr <= {1'b0, oshr[31:1]};
          if (le_rise) begin
            rd_armed  <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_file_flat[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_cdce_spi_responder.sv
// Directed bench for cdce_spi_responder.
// Drives SPI frames through the interface and checks regs/strobes/counters.
module tb_cdce_spi_responder;
  localparam int NR = 9;

  logic          clk;
  logic          rst_n;
  logic [32*NR-1:0] reg_file_flat;
  logic          wr_stb, eeprom_stb, frame_err;
  logic [3:0]    wr_addr;
  logic [15:0]   frame_cnt;

  cdce_spi_responder_if sp();

  cdce_spi_responder #(
    .NUM_REGS(NR), .SYNC_STAGES(2), .REG_RST_VAL(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi(sp),
    .reg_file_flat(reg_file_flat),
    .wr_stb(wr_stb), .wr_addr(wr_addr),
    .eeprom_stb(eeprom_stb), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int ee_cnt = 0;
  int err_cnt = 0;
  logic [3:0] wr_log[$];

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt <= wr_cnt + 1;
      wr_log.push_back(wr_addr);
    end
    if (eeprom_stb) ee_cnt <= ee_cnt + 1;
    if (frame_err)  err_cnt <= err_cnt + 1;
  end

  function automatic logic [31:0] rg(input int n);
    return reg_file_flat[n*32 +: 32];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic frame_start();
    sp.spi_le = 1'b0;
    #40;
  endtask

  task automatic shift_bits(input logic [31:0] w, input int lo,
                            input int hi);
    for (int i = lo; i < hi; i++) begin
      sp.spi_mosi = w[i];
      #40 sp.spi_clk = 1'b1;
      #40 sp.spi_clk = 1'b0;
    end
  endtask

  task automatic frame_end();
    #40 sp.spi_le = 1'b1;
    sp.spi_mosi = 1'b0;
    #100;
  endtask

  task automatic send(input logic [31:0] w, input int n);
    frame_start();
    shift_bits(w, 0, n);
    frame_end();
  endtask

  task automatic read_frame(output logic [31:0] got);
    frame_start();
    for (int i = 0; i < 32; i++) begin
      sp.spi_mosi = 1'b1;
      #40 got[i] = sp.spi_miso;
      sp.spi_clk = 1'b1;
      #40 sp.spi_clk = 1'b0;
    end
    frame_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #30;
    chk("rst_miso", 32'(sp.spi_miso), 32'h0);
    chk("rst_wr_stb", 32'(wr_stb), 32'h0);
    chk("rst_ee_stb", 32'(eeprom_stb), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    for (int n = 0; n < NR; n++)
      chk($sformatf("rst_reg%0d", n), rg(n), 32'(n));
    rst_n = 1'b1;
    #20;
  endtask

  task automatic test_write();
    int s = wr_log.size();
    int w0 = wr_cnt;
    send(32'h81400320, 32);
    send(32'h10000B25, 32);
    chk("wr_reg0", rg(0), 32'h81400320);
    chk("wr_reg5", rg(5), 32'h10000B25);
    chk("wr_stb_cnt", 32'(wr_cnt - w0), 32'd2);
    chk("wr_addr_a", 32'(wr_log[s]), 32'd0);
    chk("wr_addr_b", 32'(wr_log[s+1]), 32'd5);
    chk("wr_fcnt", 32'(frame_cnt), 32'd2);
  endtask

  task automatic test_readback();
    logic [31:0] got;
    logic [15:0] f0 = frame_cnt;
    send(32'h80009CD8, 32);
    chk("rb_reg8", rg(8), 32'h80009CD8);
    send(32'h0000008E, 32);
    chk("rb_miso_idle", 32'(sp.spi_miso), 32'h0);
    read_frame(got);
    chk("rb_data", got, 32'h80009CD8);
    chk("rb_miso_after", 32'(sp.spi_miso), 32'h0);
    chk("rb_fcnt", 32'(frame_cnt - f0), 32'd3);
    chk("rb_reg0_kept", rg(0), 32'h81400320);
  endtask

  task automatic test_short_frame();
    int e0 = err_cnt;
    int w0 = wr_cnt;
    logic [15:0] f0 = frame_cnt;
    send(32'h12345671, 31);
    chk("short_err", 32'(err_cnt - e0), 32'd1);
    chk("short_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("short_reg1", rg(1), 32'h1);
    chk("short_reg0", rg(0), 32'h81400320);
    chk("short_fcnt", 32'(frame_cnt), 32'(f0));
    send(32'h12345671, 32);
    chk("short_next_reg1", rg(1), 32'h12345671);
    chk("short_next_fcnt", 32'(frame_cnt), 32'(f0 + 16'd1));
    chk("short_next_err", 32'(err_cnt - e0), 32'd1);
  endtask

  task automatic test_eeprom_bad_cmd();
    int e0 = err_cnt;
    int w0 = wr_cnt;
    int x0 = ee_cnt;
    logic [15:0] f0 = frame_cnt;
    send(32'h0000001F, 32);
    chk("ee_stb", 32'(ee_cnt - x0), 32'd1);
    chk("ee_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("ee_reg5", rg(5), 32'h10000B25);
    chk("ee_reg1", rg(1), 32'h12345671);
    send(32'h0000000C, 32);
    chk("badcmd_err", 32'(err_cnt - e0), 32'd1);
    chk("badcmd_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("badcmd_fcnt", 32'(frame_cnt), 32'(f0 + 16'd2));
  endtask

  task automatic test_oob_read();
    logic [31:0] got;
    send(32'hFFFFFFDE, 32);
    chk("oob_miso_before", 32'(sp.spi_miso), 32'h0);
    read_frame(got);
    chk("oob_data", got, 32'h0);
    chk("oob_miso_after", 32'(sp.spi_miso), 32'h0);
    send(32'h0000003E, 32);
    read_frame(got);
    chk("rb_reg3_rst", got, 32'h3);
  endtask

  task automatic test_mid_reset();
    int w0 = wr_cnt;
    frame_start();
    shift_bits(32'hCAFE0002, 0, 16);
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    shift_bits(32'hCAFE0002, 16, 32);
    frame_end();
    chk("mr_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("mr_reg2", rg(2), 32'h2);
    chk("mr_reg0", rg(0), 32'h0);
    chk("mr_fcnt", 32'(frame_cnt), 32'd0);
    send(32'hCAFE0002, 32);
    chk("mr_next_reg2", rg(2), 32'hCAFE0002);
    chk("mr_next_wr", 32'(wr_cnt - w0), 32'd1);
    chk("mr_next_fcnt", 32'(frame_cnt), 32'd1);
  endtask

  initial begin
    sp.spi_clk  = 1'b0;
    sp.spi_le   = 1'b1;
    sp.spi_mosi = 1'b0;
    rst_n       = 1'b0;
    #3;
    test_reset();
    test_write();
    test_readback();
    test_short_frame();
    test_eeprom_bad_cmd();
    test_oob_read();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
